// File: rtl/kvs_xfer_scheduler.sv
// Splits a host transfer into engine chunks of at most C_CHUNK_BYTES and
// issues them one at a time, reporting completion to the host.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a rising ap_start edge
// ISSUE  | eng_start is high (rem != 0), or about to finish (rem == 0)
// WAIT   | chunk in flight, waiting for eng_done
// FINISH | ap_done is high for this one cycle
module kvs_xfer_scheduler #(
  parameter int C_ADDR_WIDTH  = 64,
  parameter int C_CHUNK_BYTES = 4096
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    ap_start,
  output logic                    ap_idle,
  output logic                    ap_done,
  input  logic [31:0]             data_num,
  input  logic [63:0]             axi00_ptr0,
  output logic                    eng_start,
  output logic [C_ADDR_WIDTH-1:0] eng_addr,
  output logic [31:0]             eng_size,
  input  logic                    eng_done,
  output logic [31:0]             chunk_cnt
);

  localparam logic [31:0] CHUNK = 32'(C_CHUNK_BYTES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    ap_start_q;
  logic                    ap_start_pulse;
  logic                    accept;
  logic                    retire;
  logic [31:0]             rem;
  logic [31:0]             rem_nxt;
  logic [C_ADDR_WIDTH-1:0] addr;
  logic [C_ADDR_WIDTH-1:0] addr_nxt;
  logic [31:0]             cnt_nxt;
  logic                    eng_start_d;
  logic [C_ADDR_WIDTH-1:0] eng_addr_d;
  logic [31:0]             eng_size_d;
  logic                    ap_done_d;
  logic                    ap_idle_d;

  assign ap_start_pulse = ap_start & ~ap_start_q;
  assign accept         = (state == S_IDLE) && ap_start_pulse;
  assign retire         = (state == S_WAIT) && eng_done;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (ap_start_pulse) state_nxt = S_ISSUE;
      S_ISSUE:  state_nxt = (rem == 32'd0) ? S_FINISH : S_WAIT;
      S_WAIT:   if (eng_done) state_nxt = S_ISSUE;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Job bookkeeping as it will stand after this edge; the registered outputs
  // below are loaded from it so eng_start lands in the ISSUE cycle itself.
  always_comb begin
    rem_nxt  = rem;
    addr_nxt = addr;
    cnt_nxt  = chunk_cnt;
    if (accept) begin
      rem_nxt  = data_num;
      addr_nxt = axi00_ptr0[C_ADDR_WIDTH-1:0];
      cnt_nxt  = 32'd0;
    end else if (retire) begin
      rem_nxt  = rem - eng_size;
      addr_nxt = addr + C_ADDR_WIDTH'(eng_size);
      cnt_nxt  = chunk_cnt + 32'd1;
    end
  end

  always_comb begin
    eng_start_d = (state_nxt == S_ISSUE) && (rem_nxt != 32'd0);
    ap_done_d   = (state_nxt == S_FINISH);
    ap_idle_d   = (state_nxt == S_IDLE);
    eng_addr_d  = eng_addr;
    eng_size_d  = eng_size;
    if (eng_start_d) begin
      eng_addr_d = addr_nxt;
      eng_size_d = (rem_nxt < CHUNK) ? rem_nxt : CHUNK;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ap_start_q <= 1'b0;
      rem        <= 32'd0;
      addr       <= '0;
      chunk_cnt  <= 32'd0;
      eng_start  <= 1'b0;
      eng_addr   <= '0;
      eng_size   <= 32'd0;
      ap_done    <= 1'b0;
      ap_idle    <= 1'b1;
    end else begin
      ap_start_q <= ap_start;
      rem        <= rem_nxt;
      addr       <= addr_nxt;
      chunk_cnt  <= cnt_nxt;
      eng_start  <= eng_start_d;
      eng_addr   <= eng_addr_d;
      eng_size   <= eng_size_d;
      ap_done    <= ap_done_d;
      ap_idle    <= ap_idle_d;
    end
  end

endmodule

// File: tb/tb_kvs_xfer_scheduler.sv
// Bench for kvs_xfer_scheduler: a chunk-list model predicts every output each
// cycle, and directed jobs pin that model with hand-computed values.
module tb_kvs_xfer_scheduler;

  localparam int unsigned CB = 4096;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        ap_start;
  logic        ap_idle;
  logic        ap_done;
  logic [31:0] data_num;
  logic [63:0] axi00_ptr0;
  logic        eng_start;
  logic [63:0] eng_addr;
  logic [31:0] eng_size;
  logic        eng_done;
  logic [31:0] chunk_cnt;

  logic resp_done, stray_done, resp_en, chk_en;
  int   resp_timer;
  assign eng_done = resp_done | stray_done;

  kvs_xfer_scheduler #(.C_ADDR_WIDTH(64), .C_CHUNK_BYTES(CB)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
    .ap_idle(ap_idle), .ap_done(ap_done), .data_num(data_num),
    .axi00_ptr0(axi00_ptr0), .eng_start(eng_start), .eng_addr(eng_addr),
    .eng_size(eng_size), .eng_done(eng_done), .chunk_cnt(chunk_cnt)
  );

  always #5 ap_clk = ~ap_clk;

  int n_err = 0;
  int n_checks = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge ap_clk);
    cyc++;
  end

  // Engine stand-in: returns eng_done 10 cycles after each eng_start.
  initial begin
    resp_done  = 1'b0;
    resp_timer = 0;
    forever begin
      @(posedge ap_clk);
      #1;
      resp_done = 1'b0;
      if (!ap_rst_n) begin
        resp_timer = 0;
      end else begin
        if (resp_timer > 0) begin
          resp_timer--;
          if (resp_timer == 0) resp_done = 1'b1;
        end
        if (eng_start && resp_en) resp_timer = 10;
      end
    end
  end

  // Behavioural model: a job is a precomputed list of chunks; timing follows
  // the latency rules (start +1, eng_done +1 to next chunk, +2 to ap_done).
  typedef struct {
    logic [63:0] a;
    logic [31:0] s;
  } chunk_t;

  chunk_t      mq[$];
  logic        m_sq = 1'b0, m_job = 1'b0, m_wait = 1'b0;
  int          m_done_in = 0;
  logic        e_start = 1'b0, e_done = 1'b0, e_idle = 1'b1;
  logic [63:0] e_addr = '0;
  logic [31:0] e_size = '0;
  int          e_cnt = 0;

  initial forever begin
    logic        pulse, was_start, was_done;
    int unsigned left, sz;
    logic [63:0] a;
    chunk_t      c;
    @(posedge ap_clk or negedge ap_rst_n);
    if (!ap_rst_n) begin
      m_sq = 0; m_job = 0; m_wait = 0; m_done_in = 0; mq.delete();
      e_start = 0; e_done = 0; e_idle = 1; e_cnt = 0; e_addr = '0; e_size = '0;
    end else begin
      pulse     = ap_start && !m_sq;
      m_sq      = ap_start;
      was_start = e_start;
      was_done  = e_done;
      e_start   = 0;
      e_done    = 0;
      if (was_start) m_wait = 1;
      if (m_done_in > 0) begin
        m_done_in--;
        if (m_done_in == 0) e_done = 1;
      end
      if (was_done) begin
        m_job  = 0;
        e_idle = 1;
      end else if (!m_job && pulse) begin
        m_job = 1; e_idle = 0; e_cnt = 0; mq.delete();
        left = data_num;
        a    = axi00_ptr0;
        while (left != 0) begin
          sz  = (left < CB) ? left : CB;
          c.a = a; c.s = sz;
          mq.push_back(c);
          a    = a + 64'(sz);
          left = left - sz;
        end
        if (mq.size() == 0) m_done_in = 1;
        else begin e_start = 1; e_addr = mq[0].a; e_size = mq[0].s; end
      end else if (m_job && m_wait && eng_done) begin
        m_wait = 0;
        void'(mq.pop_front());
        e_cnt++;
        if (mq.size() == 0) m_done_in = 1;
        else begin e_start = 1; e_addr = mq[0].a; e_size = mq[0].s; end
      end
    end
  end

  initial forever begin
    @(negedge ap_clk);
    if (chk_en) begin
      chk("ap_idle", 64'(ap_idle), 64'(e_idle));
      chk("ap_done", 64'(ap_done), 64'(e_done));
      chk("eng_start", 64'(eng_start), 64'(e_start));
      chk("chunk_cnt", 64'(chunk_cnt), 64'(e_cnt));
      if (e_start || m_wait || !ap_rst_n) begin
        chk("eng_addr", eng_addr, e_addr);
        chk("eng_size", 64'(eng_size), 64'(e_size));
      end
    end
  end

  logic [63:0] log_addr[$];
  logic [31:0] log_size[$];
  int          log_cyc[$];
  int          done_cnt = 0, done_cyc = 0, edone_cyc = 0;

  initial forever begin
    @(negedge ap_clk);
    if (eng_start === 1'b1) begin
      log_addr.push_back(eng_addr);
      log_size.push_back(eng_size);
      log_cyc.push_back(cyc);
    end
    if (ap_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (eng_done && ap_rst_n) edone_cyc = cyc;
  end

  task automatic step(input int n);
    repeat (n) @(posedge ap_clk);
    #1;
  endtask

  task automatic start_job(input logic [31:0] n, input logic [63:0] p, output int pc);
    @(posedge ap_clk); #1;
    data_num = n; axi00_ptr0 = p; ap_start = 1'b1; pc = cyc;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget);
    int k = 0;
    while (done_cnt == base && k < budget) begin
      @(posedge ap_clk);
      k++;
    end
    #1;
    if (done_cnt == base) begin
      n_checks++; n_err++;
      $display("FAIL wait_done: no ap_done within %0d cycles, required one pulse", budget);
    end
  endtask

  task automatic wait_starts(input int target, input int budget);
    int k = 0;
    while (log_addr.size() < target && k < budget) begin
      @(posedge ap_clk);
      k++;
    end
    #1;
    if (log_addr.size() < target) begin
      n_checks++; n_err++;
      $display("FAIL wait_starts: %0d eng_starts logged, required %0d", log_addr.size(), target);
    end
  endtask

  initial begin
    int b, bd, pc, r;
    ap_rst_n = 1'b0; ap_start = 1'b0; data_num = '0; axi00_ptr0 = '0;
    stray_done = 1'b0; resp_en = 1'b1; chk_en = 1'b0;
    step(3);
    chk_en = 1'b1;
    chk("rst_idle", 64'(ap_idle), 64'd1);
    chk("rst_eng_start", 64'(eng_start), 64'd0);
    chk("rst_eng_addr", eng_addr, 64'd0);
    chk("rst_chunk_cnt", 64'(chunk_cnt), 64'd0);
    ap_rst_n = 1'b1;
    step(2);

    // Exact multiple of the chunk size
    b = log_addr.size(); bd = done_cnt;
    start_job(32'd8192, 64'h1000, pc);
    wait_done(bd, 100);
    chk("mult_nstarts", 64'(log_addr.size() - b), 64'd2);
    chk("mult_addr0", log_addr[b], 64'h1000);
    chk("mult_size0", 64'(log_size[b]), 64'd4096);
    chk("mult_addr1", log_addr[b+1], 64'h2000);
    chk("mult_size1", 64'(log_size[b+1]), 64'd4096);
    chk("mult_first_lat", 64'(log_cyc[b] - pc), 64'd1);
    chk("mult_next_lat", 64'(log_cyc[b+1] - log_cyc[b]), 64'd11);
    chk("mult_done_lat", 64'(done_cyc - edone_cyc), 64'd2);
    chk("mult_cnt", 64'(chunk_cnt), 64'd2);
    chk("mult_idle", 64'(ap_idle), 64'd1);
    step(3);

    // Short final chunk
    b = log_addr.size(); bd = done_cnt;
    start_job(32'd4160, 64'h20000, pc);
    wait_done(bd, 100);
    chk("rem_size0", 64'(log_size[b]), 64'd4096);
    chk("rem_size1", 64'(log_size[b+1]), 64'd64);
    chk("rem_addr1", log_addr[b+1], 64'h21000);
    chk("rem_cnt", 64'(chunk_cnt), 64'd2);
    step(3);

    // Zero length
    b = log_addr.size(); bd = done_cnt;
    start_job(32'd0, 64'h3000, pc);
    wait_done(bd, 20);
    chk("zero_nstarts", 64'(log_addr.size() - b), 64'd0);
    chk("zero_done_lat", 64'(done_cyc - pc), 64'd2);
    chk("zero_cnt", 64'(chunk_cnt), 64'd0);
    step(3);

    // Start edges and new parameters while busy, one edge on an eng_done cycle
    resp_en = 1'b0;
    b = log_addr.size(); bd = done_cnt;
    start_job(32'd8192, 64'h4000, pc);
    wait_starts(b + 1, 20);
    step(3);
    data_num = 32'd100; axi00_ptr0 = 64'h0; ap_start = 1'b1;
    step(1);
    ap_start = 1'b0;
    step(2);
    ap_start = 1'b1; stray_done = 1'b1;
    step(1);
    stray_done = 1'b0;
    step(1);
    ap_start = 1'b0;
    wait_starts(b + 2, 20);
    step(4);
    stray_done = 1'b1;
    step(1);
    stray_done = 1'b0;
    wait_done(bd, 20);
    chk("busy_nstarts", 64'(log_addr.size() - b), 64'd2);
    chk("busy_addr0", log_addr[b], 64'h4000);
    chk("busy_addr1", log_addr[b+1], 64'h5000);
    chk("busy_size1", 64'(log_size[b+1]), 64'd4096);
    chk("busy_cnt", 64'(chunk_cnt), 64'd2);
    resp_en = 1'b1;
    step(3);

    // Reset in the middle of a job, then a stale eng_done
    b = log_addr.size(); bd = done_cnt;
    start_job(32'd8192, 64'h8000, pc);
    wait_starts(b + 1, 20);
    step(3);
    ap_rst_n = 1'b0;
    step(2);
    ap_rst_n = 1'b1;
    step(2);
    stray_done = 1'b1;
    step(1);
    stray_done = 1'b0;
    step(15);
    chk("rstmid_no_done", 64'(done_cnt - bd), 64'd0);
    chk("rstmid_nstarts", 64'(log_addr.size() - b), 64'd1);
    chk("rstmid_cnt", 64'(chunk_cnt), 64'd0);
    chk("rstmid_idle", 64'(ap_idle), 64'd1);
    b = log_addr.size(); bd = done_cnt;
    start_job(32'd100, 64'h10, pc);
    wait_done(bd, 40);
    chk("post_addr", log_addr[b], 64'h10);
    chk("post_size", 64'(log_size[b]), 64'd100);
    chk("post_cnt", 64'(chunk_cnt), 64'd1);
    step(3);

    // ap_start already high when reset is released
    b = log_addr.size(); bd = done_cnt;
    data_num = 32'd64; axi00_ptr0 = 64'h100; ap_start = 1'b1;
    ap_rst_n = 1'b0;
    step(2);
    ap_rst_n = 1'b1; r = cyc;
    wait_done(bd, 40);
    ap_start = 1'b0;
    chk("rel_start_cyc", 64'(log_cyc[b] - r), 64'd1);
    chk("rel_addr", log_addr[b], 64'h100);
    chk("rel_size", 64'(log_size[b]), 64'd64);
    chk("rel_cnt", 64'(chunk_cnt), 64'd1);
    step(3);

    // Address wrap past 2^64
    b = log_addr.size(); bd = done_cnt;
    start_job(32'd8192, 64'hFFFF_FFFF_FFFF_F000, pc);
    wait_done(bd, 100);
    chk("wrap_addr0", log_addr[b], 64'hFFFF_FFFF_FFFF_F000);
    chk("wrap_addr1", log_addr[b+1], 64'h0);
    chk("wrap_cnt", 64'(chunk_cnt), 64'd2);
    step(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
